// File: rtl/atom_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | atom_mem_arbiter_if : core, ioctl download and RAM port bundle     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface atom_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [17:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic        dl_active;
  logic        dl_error;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  mem_dout,
    output cpu_rdata, cpu_rvalid, ioctl_wait,
    output mem_addr, mem_din, mem_we, dl_active, dl_error
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output mem_dout,
    input  cpu_rdata, cpu_rvalid, ioctl_wait,
    input  mem_addr, mem_din, mem_we, dl_active, dl_error
  );
endinterface
`default_nettype wire

// File: rtl/atom_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | atom_mem_arbiter : shares system RAM between core and HPS download |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module atom_mem_arbiter #(
  parameter logic [17:0] DL_BASE  = 18'h17000,
  parameter int          DL_SIZE  = 4096,
  parameter logic [7:0]  DL_INDEX = 8'd1,
  parameter int          FIFO_AW  = 3
) (
  input  logic                clk_sys_i,
  input  logic                reset_i,
  atom_mem_arbiter_if.slave   bus
);
  localparam int c_ow    = $clog2(DL_SIZE);
  localparam int c_depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] c_full     = (FIFO_AW + 1)'(c_depth);
  localparam logic [FIFO_AW:0] c_wait_thr = (FIFO_AW + 1)'(c_depth - 2);
  localparam logic [FIFO_AW:0] c_one      = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {
    DL_IDLE   = 2'd0,
    DL_ACTIVE = 2'd1,
    DL_DRAIN  = 2'd2
  } dl_state_e;

  dl_state_e          state_q, state_d;
  logic [c_ow-1:0]    fifo_off_q [c_depth];
  logic [7:0]         fifo_dat_q [c_depth];
  logic [FIFO_AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               pipe_q, rvalid_q, wait_q, err_q, err_d;
  logic [7:0]         rdata_q;

  logic w_empty, w_full, w_in_range, w_wr_attempt, w_push, w_drop, w_pop, w_start;

  assign w_empty      = (count_q == '0);
  assign w_full       = (count_q == c_full);
  assign w_in_range   = (bus.ioctl_addr < 25'(DL_SIZE));
  assign w_wr_attempt = bus.ioctl_wr && (state_q == DL_ACTIVE);
  assign w_push       = w_wr_attempt && w_in_range && !w_full;
  assign w_drop       = w_wr_attempt && !(w_in_range && !w_full);
  // The core owns every cycle it requests; the FIFO only fills the gaps.
  assign w_pop        = !bus.cpu_req && !w_empty && (state_q != DL_IDLE);
  assign w_start      = (state_q == DL_IDLE) && bus.ioctl_download &&
                        (bus.ioctl_index == DL_INDEX);

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + c_one;
    end else if (!w_push && w_pop) begin
      count_d = count_q - c_one;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      DL_IDLE:   if (w_start) state_d = DL_ACTIVE;
      DL_ACTIVE: if (!bus.ioctl_download) state_d = DL_DRAIN;
      // Leave as soon as the last queued byte is being written.
      DL_DRAIN:  if (count_d == '0) state_d = DL_IDLE;
      default:   state_d = DL_IDLE;
    endcase
    if (w_start) begin
      err_d = 1'b0;
    end else if (w_drop) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    bus.mem_addr = bus.cpu_addr;
    bus.mem_din  = bus.cpu_wdata;
    bus.mem_we   = 1'b0;
    if (bus.cpu_req) begin
      bus.mem_we = bus.cpu_we;
    end else if (w_pop) begin
      bus.mem_addr = DL_BASE | 18'(fifo_off_q[rd_ptr_q]);
      bus.mem_din  = fifo_dat_q[rd_ptr_q];
      bus.mem_we   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (w_push) begin
      fifo_off_q[wr_ptr_q] <= bus.ioctl_addr[c_ow-1:0];
      fifo_dat_q[wr_ptr_q] <= bus.ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= DL_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pipe_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 8'h00;
      wait_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      err_q    <= err_d;
      wait_q   <= (count_q >= c_wait_thr);
      pipe_q   <= bus.cpu_req && !bus.cpu_we;
      rvalid_q <= pipe_q;
      if (pipe_q) rdata_q <= bus.mem_dout;
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.dl_active  = (state_q != DL_IDLE);
  assign bus.dl_error   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_atom_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_atom_mem_arbiter : scoreboard bench with a behavioural RAM      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_atom_mem_arbiter;
  localparam logic [17:0] DL_BASE  = 18'h17000;
  localparam int          DL_SIZE  = 4096;
  localparam logic [7:0]  DL_INDEX = 8'd1;
  localparam int          FIFO_AW  = 3;
  localparam int          D        = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  atom_mem_arbiter_if bus();
  atom_mem_arbiter #(.DL_BASE(DL_BASE), .DL_SIZE(DL_SIZE), .DL_INDEX(DL_INDEX),
                     .FIFO_AW(FIFO_AW))
    dut (.clk_sys_i(clk), .reset_i(rst), .bus(bus));

  // Synchronous-read RAM with unregistered output
  logic [7:0]  ram [0:196607];
  logic [17:0] ram_raddr = '0;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    ram_raddr <= bus.mem_addr;
  end
  assign bus.mem_dout = ram[ram_raddr];

  typedef struct { logic [7:0] d; int due; } rd_t;
  rd_t        rdq[$];
  logic [25:0] dlq[$];
  logic [7:0] exp_mem [int];
  int  total = 0, bad = 0, cyc = 0, occ_last = 0;
  bit  exp_err = 0, m_active = 0, exp_wait = 0;
  logic [25:0] mon_e;
  rd_t         mon_r;

  function automatic logic [7:0] init_pat(input int a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] exp_rd(input int a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return init_pat(a);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Wait flag reflects the FIFO level of the previous cycle
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      occ_last = 0;
      exp_wait = 0;
    end else begin
      exp_wait = (occ_last >= D - 2);
      occ_last = dlq.size();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ioctl_wait", bus.ioctl_wait, exp_wait);
      if (bus.cpu_req) begin
        chk("core_we", bus.mem_we, bus.cpu_we);
        chk("core_addr", bus.mem_addr, bus.cpu_addr);
        if (bus.cpu_we) chk("core_din", bus.mem_din, bus.cpu_wdata);
      end else if (bus.mem_we) begin
        if (dlq.size() == 0) begin
          chk("unexpected_dl_write", bus.mem_we, 0);
        end else begin
          mon_e = dlq.pop_front();
          chk("dl_addr", bus.mem_addr, mon_e[25:8]);
          chk("dl_data", bus.mem_din, mon_e[7:0]);
          exp_mem[int'(mon_e[25:8])] = mon_e[7:0];
        end
      end
      if (bus.cpu_rvalid) begin
        if (rdq.size() == 0) begin
          chk("unexpected_rvalid", bus.cpu_rvalid, 0);
        end else begin
          mon_r = rdq.pop_front();
          chk("rdata", bus.cpu_rdata, mon_r.d);
          chk("rvalid_cycle", cyc, mon_r.due);
        end
      end else if (rdq.size() > 0 && rdq[0].due < cyc) begin
        chk("rvalid_missing", bus.cpu_rvalid, 1);
        void'(rdq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.cpu_req  = 1'b0;
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic core(input bit we, input int a, input logic [7:0] d);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = 18'(a);
    bus.cpu_wdata = d;
    if (we) exp_mem[a] = d;
    else    rdq.push_back('{d: exp_rd(a), due: cyc + 2});
  endtask

  task automatic dl_byte(input int off, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'(off);
    bus.ioctl_dout = d;
    if (m_active) begin
      if (off >= DL_SIZE || dlq.size() == D) exp_err = 1;
      else dlq.push_back({DL_BASE | 18'(off), d});
    end
  endtask

  task automatic dl_start(input logic [7:0] idx);
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = idx;
    tick();
    m_active = (idx == DL_INDEX);
    if (m_active) exp_err = 0;
  endtask

  task automatic dl_stop();
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    m_active = 0;
    repeat (3) tick();
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 50; i++) begin
      if (dlq.size() == 0) break;
      tick();
    end
    chk(nm, dlq.size(), 0);
    repeat (2) tick();
  endtask

  task automatic readback(input int a);
    core(0, a, 8'h00);
    tick();
    clr();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 196608; a++) ram[a] = init_pat(a);
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ioctl_download = 0; bus.ioctl_index = '0; bus.ioctl_wr = 0;
    bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_rvalid", bus.cpu_rvalid, 0);
    chk("rst_wait", bus.ioctl_wait, 0);
    chk("rst_active", bus.dl_active, 0);
    chk("rst_error", bus.dl_error, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    rst = 1'b0;
    tick();

    // Core write then read back with two-cycle latency
    core(1, 'h0F000, 8'hA5); tick(); clr();
    readback('h0F000);
    repeat (3) tick();

    // Download of four bytes queued behind a busy core, then drained
    core(1, 'h200, 8'h77);
    dl_start(DL_INDEX);
    for (int i = 0; i < 4; i++) begin
      dl_byte(i, 8'(8'h11 * (i + 1)));
      tick();
    end
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    m_active = 0;
    tick();
    clr();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (dlq.size() == 0) break;
    end
    chk("t2_drained", dlq.size(), 0);
    chk("t2_active_last_write", bus.dl_active, 1);
    @(negedge clk); #1;
    chk("t2_active_drop", bus.dl_active, 0);
    tick();
    for (int i = 0; i < 4; i++) readback('h17000 + i);
    repeat (3) tick();

    // Core holds the RAM for 10 cycles while 3 bytes wait
    dl_start(DL_INDEX);
    for (int i = 0; i < 10; i++) begin
      core(0, 'h300 + i, 8'h00);
      if (i < 3) dl_byte('h10 + i, 8'($urandom));
      else bus.ioctl_wr = 1'b0;
      tick();
    end
    clr();
    repeat (3) tick();
    chk("t3_written_in_3", dlq.size(), 0);
    dl_stop();

    // Back-pressure and overflow with the core holding the RAM
    dl_start(DL_INDEX);
    core(1, 'h400, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      dl_byte('h20 + i, 8'($urandom));
      tick();
    end
    bus.ioctl_wr = 1'b0;
    tick();
    chk("t4_wait", bus.ioctl_wait, 1);
    for (int i = 0; i < 3; i++) begin
      dl_byte('h26 + i, 8'($urandom));
      tick();
    end
    bus.ioctl_wr = 1'b0;
    tick();
    chk("t4_error_set", bus.dl_error, 1);
    clr();
    dl_stop();
    wait_drain("t4_drain");
    dl_start(DL_INDEX);
    chk("t4_error_clear", bus.dl_error, 0);
    dl_stop();

    // Out-of-window offset and foreign index
    dl_start(DL_INDEX);
    dl_byte(4096, 8'hEE); tick(); clr(); tick();
    chk("t5_bounds_error", bus.dl_error, 1);
    dl_stop();
    dl_start(8'd0);
    for (int i = 0; i < 4; i++) begin
      dl_byte(i, 8'(8'h90 + i));
      tick();
      chk("t5_index_inactive", bus.dl_active, 0);
    end
    dl_stop();
    for (int i = 0; i < 4; i++) readback('h17000 + i);
    repeat (3) tick();

    // Randomised mix of core traffic and a download
    dl_start(DL_INDEX);
    for (int n = 0; n < 300; n++) begin
      clr();
      if ($urandom_range(0, 1) == 1)
        core(1'($urandom_range(0, 1)), 'h08000 + $urandom_range(0, 31), 8'($urandom));
      if ($urandom_range(0, 99) < (bus.ioctl_wait ? 15 : 60))
        dl_byte(($urandom_range(0, 19) == 0) ? 4096 + $urandom_range(0, 500)
                                             : $urandom_range(0, 63), 8'($urandom));
      tick();
    end
    clr();
    dl_stop();
    wait_drain("rand_drain");
    chk("rand_error", bus.dl_error, exp_err);
    chk("rand_active", bus.dl_active, 0);
    for (int i = 0; i < 64; i++) readback('h17000 + i);
    readback('h0F000);
    repeat (3) tick();

    // Reset while draining with four bytes still queued
    core(1, 'h500, 8'h11);
    dl_start(DL_INDEX);
    dl_byte(5000, 8'h00); tick();
    for (int i = 0; i < 4; i++) begin
      dl_byte('h80 + i, 8'(8'hC0 + i));
      tick();
    end
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    m_active = 0;
    tick();
    chk("t6_error_pre", bus.dl_error, 1);
    chk("t6_active_pre", bus.dl_active, 1);
    #2;
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    dlq.delete();
    rdq.delete();
    exp_err = 0;
    #1;
    chk("t6_rdata", bus.cpu_rdata, 0);
    chk("t6_rvalid", bus.cpu_rvalid, 0);
    chk("t6_wait", bus.ioctl_wait, 0);
    chk("t6_active", bus.dl_active, 0);
    chk("t6_error", bus.dl_error, 0);
    chk("t6_mem_we", bus.mem_we, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) tick();
    chk("t6_idle", bus.dl_active, 0);
    for (int i = 0; i < 4; i++) readback('h17080 + i);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
